// File: rtl/swipt_freq_gen.sv
// swipt_freq_gen: turns a requested bridge frequency (Hz) into a half-period
// count with a 32-step restoring divider. Drives complementary gate signals
// with dead time at the start of each half period. A new half count is
// switched in only at the end of a full period (end of phase 1).
// Optional feature macro: FREQ_GEN_CLAMP_EN. When it is defined, out-of-range
// requests are clamped to [FREQ_MIN, FREQ_MAX]. Otherwise they are ignored.
// Handshake: there is none. freq_req and en are levels sampled on every rising
// edge. upd_done and range_err are single-cycle strobes.
module swipt_freq_gen #(
   parameter int unsigned CLK_HZ   = 100_000_000,
   parameter int unsigned FREQ_MIN = 20_000,
   parameter int unsigned FREQ_MAX = 500_000,
   parameter int unsigned DEADTIME = 10,
   parameter int unsigned HALF_W   = 24
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        en,
   input  logic [19:0] freq_req,
   output logic        drv_hi,
   output logic        drv_lo,
   output logic [19:0] freq_applied,
   output logic        upd_done,
   output logic        busy,
   output logic        range_err,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {S_OFF = 2'd0, S_DIV = 2'd1, S_RUN = 2'd2} state_t;

   localparam logic [19:0]       FMIN_F = 20'(FREQ_MIN);
   localparam logic [19:0]       FMAX_F = 20'(FREQ_MAX);
   localparam logic [31:0]       CLK_W  = 32'(CLK_HZ);
   localparam logic [HALF_W-1:0] DT_H   = HALF_W'(DEADTIME);
   localparam logic [HALF_W-1:0] ONE_H  = HALF_W'(1);

   state_t            state_q, state_d;
   logic [19:0]       req_q, req_d, fapp_q, fapp_d, req_eff;
   logic [HALF_W-1:0] half_q, half_d, cnt_q, cnt_d, pend_half_q, pend_half_d, quo_res;
   logic              phase_q, phase_d, pend_q, pend_d, rep_q, rep_d;
   logic              hi_q, hi_d, lo_q, lo_d, upd_q, upd_d, rerr_q, rerr_d;
   logic              start_q, start_d, drun_q, drun_d, div_last, div_ge;
   logic [4:0]        it_q, it_d;
   logic [20:0]       rem_q, rem_d, dvs_q, dvs_d, rem_nxt;
   logic [21:0]       rem_sh;
   logic [31:0]       quo_q, quo_d, quo_step;

   function automatic logic in_range(input logic [19:0] f);
      return (f >= FMIN_F) && (f <= FMAX_F);
   endfunction

`ifdef FREQ_GEN_CLAMP_EN
   localparam logic CLAMP = 1'b1;
   assign req_eff = (req_q < FMIN_F) ? FMIN_F : ((req_q > FMAX_F) ? FMAX_F : req_q);
`else
   localparam logic CLAMP = 1'b0;
   assign req_eff = req_q;
`endif

   // One restoring-division step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      rem_sh   = {rem_q, quo_q[31]};
      div_ge   = (rem_sh >= {1'b0, dvs_q});
      rem_nxt  = div_ge ? (rem_sh[20:0] - dvs_q) : rem_sh[20:0];
      quo_step = {quo_q[30:0], div_ge};
      quo_res  = quo_step[HALF_W-1:0];
      div_last = drun_q && (it_q == 5'd31);
   end

   // Next-state logic for the FSM, the divider and the period counter. Disable overrides everything.
   always_comb begin
      state_d = state_q;  req_d = req_q;  half_d = half_q;  cnt_d = cnt_q;
      phase_d = phase_q;  pend_d = pend_q;  pend_half_d = pend_half_q;
      fapp_d = fapp_q;  rep_d = rep_q;
      rem_d = rem_q;  quo_d = quo_q;  dvs_d = dvs_q;  it_d = it_q;  drun_d = drun_q;
      hi_d = 1'b0;  lo_d = 1'b0;  upd_d = 1'b0;  rerr_d = 1'b0;  start_d = 1'b0;

      // The divider only ever starts on a legal (or clamped) value, so the divisor is never 0.
      if (start_q) begin
         rem_d  = '0;
         quo_d  = CLK_W;
         dvs_d  = {req_eff, 1'b0};
         it_d   = '0;
         drun_d = 1'b1;
      end else if (drun_q) begin
         rem_d = rem_nxt;
         quo_d = quo_step;
         it_d  = it_q + 5'd1;
         if (div_last) drun_d = 1'b0;
      end

      case (state_q)
         S_OFF: begin
            cnt_d   = '0;
            phase_d = 1'b0;
            if (en) begin
               req_d = freq_req;
               if (CLAMP || in_range(freq_req)) begin
                  state_d = S_DIV;
                  start_d = 1'b1;
                  rerr_d  = !in_range(freq_req);
                  rep_d   = 1'b0;
               end else if (!rep_q || (freq_req != req_q)) begin
                  // Report an illegal value once, not on every cycle it is held.
                  rerr_d = 1'b1;
                  rep_d  = 1'b1;
               end
            end
         end
         S_DIV: begin
            if (upd_q) begin
               state_d = S_RUN;
               cnt_d   = '0;
               phase_d = 1'b0;
            end else if (div_last) begin
               half_d = quo_res;
               fapp_d = req_eff;
               upd_d  = 1'b1;
            end
         end
         S_RUN: begin
            hi_d = !phase_q && (cnt_q >= DT_H);
            lo_d = phase_q && (cnt_q >= DT_H);
            if (cnt_q == half_q - ONE_H) begin
               cnt_d   = '0;
               phase_d = !phase_q;
               // Switching at the end of phase 1 keeps every period whole.
               if (phase_q && pend_q) begin
                  half_d = pend_half_q;
                  fapp_d = req_eff;
                  pend_d = 1'b0;
                  upd_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + ONE_H;
            end
            if (div_last) begin
               pend_half_d = quo_res;
               pend_d      = 1'b1;
            end else if ((freq_req != req_q) && !start_q && !drun_q && !pend_q) begin
               req_d  = freq_req;
               rerr_d = !in_range(freq_req);
               if (CLAMP || in_range(freq_req)) start_d = 1'b1;
            end
         end
         default: state_d = S_OFF;
      endcase

      if (!en) begin
         state_d = S_OFF;  hi_d = 1'b0;  lo_d = 1'b0;
         start_d = 1'b0;  drun_d = 1'b0;  pend_d = 1'b0;  fapp_d = '0;
         cnt_d = '0;  phase_d = 1'b0;  upd_d = 1'b0;  rerr_d = 1'b0;  rep_d = 1'b0;
      end
   end

   // State register. nrst clears everything, including the latched request.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q <= S_OFF;  req_q <= '0;  half_q <= '0;  cnt_q <= '0;  phase_q <= 1'b0;
         pend_q <= 1'b0;  pend_half_q <= '0;  fapp_q <= '0;  rep_q <= 1'b0;
         hi_q <= 1'b0;  lo_q <= 1'b0;  upd_q <= 1'b0;  rerr_q <= 1'b0;  start_q <= 1'b0;
         drun_q <= 1'b0;  it_q <= '0;  rem_q <= '0;  quo_q <= '0;  dvs_q <= '0;
      end else begin
         state_q <= state_d;  req_q <= req_d;  half_q <= half_d;  cnt_q <= cnt_d;
         phase_q <= phase_d;  pend_q <= pend_d;  pend_half_q <= pend_half_d;
         fapp_q <= fapp_d;  rep_q <= rep_d;  hi_q <= hi_d;  lo_q <= lo_d;
         upd_q <= upd_d;  rerr_q <= rerr_d;  start_q <= start_d;  drun_q <= drun_d;
         it_q <= it_d;  rem_q <= rem_d;  quo_q <= quo_d;  dvs_q <= dvs_d;
      end
   end

   assign drv_hi       = hi_q;
   assign drv_lo       = lo_q;
   assign freq_applied = fapp_q;
   assign upd_done     = upd_q;
   assign range_err    = rerr_q;
   assign busy         = start_q | drun_q | pend_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_swipt_freq_gen.sv
// Testbench for swipt_freq_gen.
// Startup vector table, hand-written sequences and randomized retuning.
// Checked against an arithmetic model: half = CLK_HZ / (2 * f).
module tb_swipt_freq_gen;
  localparam int CLK_HZ = 100_000_000;
  localparam int DT     = 10;
`ifdef FREQ_GEN_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic clk = 1'b0;
  logic nrst, en;
  logic [19:0] freq_req;
  logic drv_hi, drv_lo, upd_done, busy, range_err;
  logic [19:0] freq_applied;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  swipt_freq_gen dut (
    .clk(clk), .nrst(nrst), .en(en), .freq_req(freq_req),
    .drv_hi(drv_hi), .drv_lo(drv_lo), .freq_applied(freq_applied),
    .upd_done(upd_done), .busy(busy), .range_err(range_err), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int overlap = 0;
  logic [19:0] exp_q[$];

  typedef struct {
    int freq;
    bit starts;
    int applied;
    int half;
    int err;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int half_of(input int f);
    return CLK_HZ / (2 * f);
  endfunction

  // Scoreboard: every update strobe must apply the oldest outstanding expected frequency.
  always @(negedge clk) begin
    if (nrst === 1'b1 && upd_done === 1'b1) begin
      if (exp_q.size() == 0) check("upd_unexpected", 1, 0);
      else check("upd_freq", int'(freq_applied), int'(exp_q.pop_front()));
    end
  end

  // Pulse monitor: widths follow the frequency shown at pulse start, with dead-time gaps between pulses.
  int hi_len, lo_len, hi_f, lo_f, gap;
  bit prev_hi, prev_lo, gap_ok;
  always @(negedge clk) begin
    if (drv_hi === 1'b1 && drv_lo === 1'b1) overlap++;
    if (nrst !== 1'b1 || freq_applied == 20'd0) begin
      prev_hi = 1'b0; prev_lo = 1'b0; gap_ok = 1'b0; gap = 0;
    end else begin
      if (drv_hi && !prev_hi) begin
        if (gap_ok) check("gap_before_hi", gap, DT);
        hi_len = 0; hi_f = int'(freq_applied);
      end
      if (drv_lo && !prev_lo) begin
        if (gap_ok) check("gap_before_lo", gap, DT);
        lo_len = 0; lo_f = int'(freq_applied);
      end
      if (drv_hi) hi_len++;
      if (drv_lo) lo_len++;
      if (!drv_hi && prev_hi) begin
        check("hi_width", hi_len, half_of(hi_f) - DT); gap_ok = 1'b1; gap = 0;
      end
      if (!drv_lo && prev_lo) begin
        check("lo_width", lo_len, half_of(lo_f) - DT); gap_ok = 1'b1; gap = 0;
      end
      if (!drv_hi && !drv_lo) gap++;
      prev_hi = drv_hi; prev_lo = drv_lo;
    end
  end

  task automatic wait_upd(input int bound, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (upd_done) seen = 1'b1;
    end
    check(name, int'(seen), 1);
  endtask

  task automatic wait_drive(input bit lo_side, input int bound, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (lo_side ? drv_lo : drv_hi) seen = 1'b1;
    end
    check(name, int'(seen), 1);
  endtask

  task automatic disable_bridge();
    en = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
  endtask

  task automatic run_startup(input vec_t v);
    int upd_k = -1;
    int hi_k = -1;
    int errs = 0;
    int n = 0;
    bit drove = 1'b0;
    disable_bridge();
    if (v.starts) exp_q.push_back(20'(v.applied));
    freq_req = 20'(v.freq);
    en = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (upd_done && upd_k < 0) upd_k = k;
      if (drv_hi && hi_k < 0) hi_k = k;
      if (drv_hi || drv_lo) drove = 1'b1;
      if (range_err) errs++;
    end
    check("start_range_err", errs, v.err);
    if (v.starts) begin
      check("start_upd_cycle", upd_k, 33);
      check("start_first_hi", hi_k, 35 + DT);
      check("start_applied", int'(freq_applied), v.applied);
      wait_drive(1'b1, 6000, "start_lo_seen");
      while (drv_lo === 1'b1 && n < 6000) begin
        n++;
        @(negedge clk);
      end
      check("start_lo_width", n, v.half - DT);
    end else begin
      check("off_no_drive", int'(drove), 0);
      check("off_applied", int'(freq_applied), 0);
      check("off_busy", int'(busy), 0);
    end
  endtask

  initial begin
    int upd_k, errs, f, last_f;
    vecs[0] = '{0,      CLAMP, 20000,  2500, 1};
    vecs[1] = '{100000, 1'b1,  100000, 500,  0};
    vecs[2] = '{20000,  1'b1,  20000,  2500, 0};
    vecs[3] = '{500000, 1'b1,  500000, 100,  0};
    vecs[4] = '{333333, 1'b1,  333333, 150,  0};
    vecs[5] = '{19999,  CLAMP, 20000,  2500, 1};
    vecs[6] = '{600000, CLAMP, 500000, 100,  1};

    // Reset state
    nrst = 1'b0; en = 1'b0; freq_req = '0;
    repeat (3) @(negedge clk);
    check("rst_drv_hi", int'(drv_hi), 0);
    check("rst_drv_lo", int'(drv_lo), 0);
    check("rst_applied", int'(freq_applied), 0);
    check("rst_upd", int'(upd_done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_range_err", int'(range_err), 0);
    nrst = 1'b1;
    @(negedge clk);

    // Startup vectors, including zero and out-of-range requests
    for (int i = 0; i < 7; i++) run_startup(vecs[i]);

    // Retune 100k -> 125k mid phase 0; switch only at the phase1->0 boundary
    disable_bridge();
    exp_q.push_back(20'd100000);
    freq_req = 20'd100000; en = 1'b1;
    wait_upd(60, "seqA_start");
    wait_drive(1'b0, 100, "seqA_hi");
    repeat (50) @(negedge clk);
    exp_q.push_back(20'd125000);
    freq_req = 20'd125000;
    wait_drive(1'b1, 1000, "seqA_lo");
    check("seqA_no_early_apply", int'(freq_applied), 100000);
    wait_upd(2000, "seqA_upd_125k");
    check("seqA_boundary_lo", int'(drv_lo), 1);
    check("seqA_boundary_hi", int'(drv_hi), 0);
    repeat (1000) @(negedge clk);

    // Out-of-range request while running
    if (CLAMP) exp_q.push_back(20'd500000);
    freq_req = 20'd600000;
    errs = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (range_err) errs++;
    end
    check("seqA_range_err", errs, 1);
    if (CLAMP) begin
      wait_upd(1000, "seqA_upd_clamp");
      check("seqA_clamped", int'(freq_applied), 500000);
    end else begin
      repeat (100) @(negedge clk);
      check("seqA_kept", int'(freq_applied), 125000);
      check("seqA_idle", int'(busy), 0);
    end
    repeat (300) @(negedge clk);

    // Disable during divide and during a high-side pulse
    disable_bridge();
    freq_req = 20'd100000; en = 1'b1;
    repeat (12) @(negedge clk);
    check("seqB_busy_mid_div", int'(busy), 1);
    en = 1'b0;
    @(negedge clk);
    check("seqB_div_drv", int'(drv_hi | drv_lo), 0);
    check("seqB_div_busy", int'(busy), 0);
    check("seqB_div_applied", int'(freq_applied), 0);
    exp_q.push_back(20'd100000);
    en = 1'b1;
    upd_k = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (upd_done && upd_k < 0) upd_k = k;
    end
    check("seqB_restart_latency", upd_k, 33);
    wait_drive(1'b0, 1000, "seqB_hi");
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("seqB_hi_drop", int'(drv_hi), 0);
    check("seqB_hi_applied", int'(freq_applied), 0);
    check("seqB_hi_busy", int'(busy), 0);
    exp_q.delete();

    // Fast toggles 100k -> 110k -> 120k, last value wins
    disable_bridge();
    exp_q.push_back(20'd100000);
    freq_req = 20'd100000; en = 1'b1;
    wait_upd(60, "seqC_start");
    repeat (20) @(negedge clk);
    exp_q.push_back(20'd110000);
    freq_req = 20'd110000;
    repeat (5) @(negedge clk);
    exp_q.push_back(20'd120000);
    freq_req = 20'd120000;
    wait_upd(3000, "seqC_upd_110k");
    wait_upd(3000, "seqC_upd_120k");
    check("seqC_final", int'(freq_applied), 120000);

    // Randomized retuning within the legal band
    last_f = 120000;
    for (int i = 0; i < 8; i++) begin
      f = int'($urandom_range(100000, 500000));
      if (f == last_f) f = f + 1;
      last_f = f;
      exp_q.push_back(20'(f));
      freq_req = 20'(f);
      wait_upd(3000, "rand_upd");
      repeat ($urandom_range(0, 600)) @(negedge clk);
    end
    repeat (1200) @(negedge clk);
    check("rand_final", int'(freq_applied), last_f);
    check("exp_q_drained", exp_q.size(), 0);
    check("no_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
